// File: rtl/stream_cipher_pkg.sv
// Shared constants, FSM state type and LFSR step for the stream cipher controller.
package stream_cipher_pkg;

    localparam int              KEY_W       = 8;
    localparam logic [KEY_W-1:0] TAPS        = 8'hB8;
    localparam logic [KEY_W-1:0] KEY_DEFAULT = 8'hCD;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // One keystream step: shift left, feed back the parity of the tapped bits.
    function automatic logic [KEY_W-1:0] lfsr_next(input logic [KEY_W-1:0] key,
                                                   input logic [KEY_W-1:0] taps);
        return {key[KEY_W-2:0], ^(key & taps)};
    endfunction

endpackage

// File: rtl/stream_cipher_rr_arb.sv
// Round-robin arbiter: searches from last_grant+1 (mod NCH) for the first request.
module stream_cipher_rr_arb #(
    parameter int NCH = 2,
    parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  last_grant,
    output logic [NCH-1:0] grant,
    output logic [IW-1:0]  grant_idx
);

    // Rotating priority search; the first hit after last_grant wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(last_grant) + i) % NCH;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_cipher_ctrl.sv
// Time-shared XOR keystream controller for NCH byte-stream channels.
// Optional per-channel keystream beat counters: define STREAM_CIPHER_CTRL_STATS_EN.
module stream_cipher_ctrl
    import stream_cipher_pkg::*;
#(
    parameter int             N           = KEY_W,
    parameter int             NCH         = 2,
    parameter logic [N-1:0]   TAPS_P      = TAPS,
    parameter logic [N-1:0]   KEY_RESET   = KEY_DEFAULT,
    parameter int             IW          = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NCH-1:0]     in_valid,
    output logic [NCH-1:0]     in_ready,
    input  logic [NCH*N-1:0]   in_data,
    input  logic [NCH-1:0]     in_mode,
    input  logic               seed_we,
    input  logic [IW-1:0]      seed_ch,
    input  logic [N-1:0]       seed_val,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_data,
    output logic [IW-1:0]      out_ch
`ifdef STREAM_CIPHER_CTRL_STATS_EN
    ,
    output logic [NCH*16-1:0]  beat_cnt
`endif
);

    state_t          state;
    logic [IW-1:0]   last_grant;
    logic [N-1:0]    key [NCH];
    logic [NCH-1:0]  seed_mask;
    logic [NCH-1:0]  req;
    logic [NCH-1:0]  grant;
    logic [IW-1:0]   grant_idx;
    logic            can_accept;
    logic            accept;
    logic [N-1:0]    sel_data;
    logic [N-1:0]    sel_key;
    logic            sel_mode;

    // A channel being seeded this cycle is kept out of arbitration.
    always_comb begin
        seed_mask = '0;
        if (seed_we) begin
            for (int c = 0; c < NCH; c++) begin
                if (int'(seed_ch) == c) seed_mask[c] = 1'b1;
            end
        end
    end

    assign req = in_valid & ~seed_mask;

    stream_cipher_rr_arb #(.NCH(NCH), .IW(IW)) u_arb (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign can_accept = (state == EMPTY) | out_ready;
    assign accept     = can_accept & (|grant);
    assign in_ready   = accept ? grant : '0;
    assign out_valid  = (state == FULL);

    assign sel_data = in_data[grant_idx*N +: N];
    assign sel_key  = key[grant_idx];
    assign sel_mode = in_mode[grant_idx];

    // Output register FSM: load on accept, drain when the sink takes the beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            out_data   <= '0;
            out_ch     <= '0;
            last_grant <= IW'(NCH - 1);
        end else if (accept) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= FULL;
            out_data   <= sel_data ^ (sel_mode ? sel_key : '0);
            out_ch     <= grant_idx;
            last_grant <= grant_idx;
        end else if (out_ready) begin
            state <= EMPTY;
        end
    end

    // Per-channel key contexts: seed load, or advance on an accepted keystream beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the key file is small and must restart from a known value, so it is reset.
            for (int c = 0; c < NCH; c++) key[c] <= KEY_RESET;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (seed_mask[c]) begin
                    key[c] <= seed_val;
                end else if (accept && grant[c] && in_mode[c]) begin
                    key[c] <= lfsr_next(key[c], TAPS_P);
                end
            end
        end
    end

`ifdef STREAM_CIPHER_CTRL_STATS_EN
    logic [15:0] cnt [NCH];

    // Saturating keystream-beat counters, cleared when the channel is seeded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) cnt[c] <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (seed_mask[c]) begin
                    cnt[c] <= '0;
                end else if (accept && grant[c] && in_mode[c] && (cnt[c] != 16'hFFFF)) begin
                    cnt[c] <= cnt[c] + 16'd1;
                end
            end
        end
    end

    // Flatten counters onto the port, channel c at [c*16 +: 16].
    always_comb begin
        beat_cnt = '0;
        for (int c = 0; c < NCH; c++) beat_cnt[c*16 +: 16] = cnt[c];
    end
`endif

endmodule

// File: tb/tb_stream_cipher_ctrl.sv
// Directed self-checking bench for stream_cipher_ctrl (NCH=2, N=8).
module tb_stream_cipher_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_mode;
    logic        seed_we;
    logic [0:0]  seed_ch;
    logic [7:0]  seed_val;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [0:0]  out_ch;
`ifdef STREAM_CIPHER_CTRL_STATS_EN
    logic [31:0] beat_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    stream_cipher_ctrl #(.N(8), .NCH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .seed_we   (seed_we),
        .seed_ch   (seed_ch),
        .seed_val  (seed_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
`ifdef STREAM_CIPHER_CTRL_STATS_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs are already set: check in_ready, clock, then check the loaded beat.
    task automatic beat(input string tag, input logic [1:0] exp_rdy,
                        input logic [7:0] exp_data, input logic exp_ch);
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
        tick();
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".out_data"}, 32'(out_data), 32'(exp_data));
        check({tag, ".out_ch"}, 32'(out_ch), 32'(exp_ch));
    endtask

    task automatic idle();
        in_valid = 2'b00;
        seed_we  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    // Let a pending beat drain with nothing offered.
    task automatic drain(input string tag);
        idle();
        out_ready = 1'b1;
        tick();
        check({tag, ".drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = '0; in_data = '0; in_mode = '0;
        seed_we = 1'b0; seed_ch = '0; seed_val = '0; out_ready = 1'b0;
        tick();
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_data",  32'(out_data),  32'd0);
        check("rst.out_ch",    32'(out_ch),    32'd0);
        check("rst.in_ready",  32'(in_ready),  32'd0);
        reset = 1'b0;

        // ch0 keystream: CD, 9A, then 35.
        out_ready = 1'b1;
        in_valid = 2'b01; in_mode = 2'b01; in_data = 16'h0000;
        beat("k0a", 2'b01, 8'hCD, 1'b0);
        beat("k0b", 2'b01, 8'h9A, 1'b0);
        beat("k0c", 2'b01, 8'h35, 1'b0);
        drain("k0");

        // Round trip on ch1 across a reset.
        in_valid = 2'b10; in_mode = 2'b10; in_data = 16'h3C00;
        beat("enc1", 2'b10, 8'hF1, 1'b1);
        do_reset();
        in_valid = 2'b10; in_mode = 2'b10; in_data = 16'hF100;
        beat("dec1", 2'b10, 8'h3C, 1'b1);
        drain("rt");

        // Fairness: both valid, grants alternate starting at ch0.
        do_reset();
        in_valid = 2'b11; in_mode = 2'b11; in_data = 16'h0000; out_ready = 1'b1;
        beat("rr0", 2'b01, 8'hCD, 1'b0);
        beat("rr1", 2'b10, 8'hCD, 1'b1);
        beat("rr2", 2'b01, 8'h9A, 1'b0);
        beat("rr3", 2'b10, 8'h9A, 1'b1);

        // Backpressure: hold 3 cycles, output frozen, nothing accepted.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp.in_ready", 32'(in_ready), 32'd0);
            tick();
            check("bp.out_valid", 32'(out_valid), 32'd1);
            check("bp.out_data",  32'(out_data),  32'h9A);
            check("bp.out_ch",    32'(out_ch),    32'd1);
        end
        out_ready = 1'b1;
        beat("rel0", 2'b01, 8'h35, 1'b0);
        beat("rel1", 2'b10, 8'h35, 1'b1);
        beat("rel2", 2'b01, 8'h6A, 1'b0);

        // Reset while FULL discards the pending beat.
        out_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;

        // Seed masks ch0 for that cycle; next beat uses the new key.
        in_valid = 2'b01; in_mode = 2'b01; in_data = 16'h0000;
        seed_we = 1'b1; seed_ch = 1'b0; seed_val = 8'h01;
        #1;
        check("seed.in_ready", 32'(in_ready), 32'd0);
        tick();
        check("seed.out_valid", 32'(out_valid), 32'd0);
        seed_we = 1'b0;
        beat("seeded", 2'b01, 8'h01, 1'b0);
        drain("seed");

        // Bypass does not consume keystream.
        do_reset();
        in_valid = 2'b01; in_mode = 2'b00; in_data = 16'h0055;
        beat("byp", 2'b01, 8'h55, 1'b0);
`ifdef STREAM_CIPHER_CTRL_STATS_EN
        check("cnt.after_bypass", 32'(beat_cnt[15:0]), 32'd0);
`endif
        in_mode = 2'b01; in_data = 16'h0000;
        beat("key_after_byp", 2'b01, 8'hCD, 1'b0);
`ifdef STREAM_CIPHER_CTRL_STATS_EN
        check("cnt.ch0", 32'(beat_cnt[15:0]),  32'd1);
        check("cnt.ch1", 32'(beat_cnt[31:16]), 32'd0);
`endif
        drain("byp");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_cipher_ctrl.md
# stream_cipher_ctrl

Session controller that time-shares one XOR keystream datapath between NCH byte-stream requesters. Each channel has its own saved LFSR key context. A round-robin arbiter grants one beat per cycle, and the granted beat is XORed with that channel's current key. Output goes to a single registered valid/ready port tagged with the channel number. Sits between the host-side channel FIFOs and the link serializer.

## Interface
- N, 8, data and key width in bits
- NCH, 2, number of requester channels (2..4)
- TAPS, 8'hB8, LFSR feedback mask; feedback is XOR of key bits where the mask bit is 1 (bits 7, 5, 4, 3)
- KEY_DEFAULT, 8'hCD, reset value of every channel key context

- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-high
- in_valid  in  NCH  per-channel beat offered
- in_ready  out  NCH  per-channel beat accepted (one-hot or zero)
- in_data  in  NCH*N  channel c occupies bits [c*N +: N]
- in_mode  in  NCH  1 = apply keystream (encrypt/decrypt), 0 = bypass
- seed_we  in  1  load a channel key context this cycle
- seed_ch  in  $clog2(NCH)  channel to seed
- seed_val  in  N  new key value
- out_valid  out  1  output beat pending
- out_ready  in  1  sink accepts output beat
- out_data  out  N  processed beat
- out_ch  out  $clog2(NCH)  channel of out_data

## Operation
- Per-channel key register key[c]; reset value KEY_DEFAULT.
- Key advance: key <= {key[N-2:0], ^(key & TAPS)}.
- FSM has 2 states:
  - EMPTY: output register free.
  - FULL: out_valid=1, holding a beat.
- Accept condition: `can_accept = (state==EMPTY) | out_ready`.
- Arbiter: round-robin over channels with in_valid=1.
  - Search starts at last_grant+1, mod NCH.
  - last_grant resets to NCH-1, so ch0 wins first.
  - last_grant updates only on an actual accept.
- When can_accept is set and a grant exists for channel g:
  - in_ready[g]=1.
  - Output register loads out_data = in_data[g] ^ (in_mode[g] ? key[g] : 0), and out_ch = g.
  - key[g] advances only if in_mode[g]=1; bypass beats do not consume keystream.
  - State → FULL.
- FULL with out_ready=1 and no new grant → EMPTY.
- FULL with out_ready=0 holds. out_data and out_ch stay stable, all in_ready=0.
- Seed write: key[seed_ch] <= seed_val.
  - Channel seed_ch is masked from arbitration that cycle, so it cannot be granted.
  - Other channels arbitrate normally.
- in_ready is combinational from in_valid, state, out_ready, seed_we and seed_ch. No data-path combinational loop exists.
- Reset mid-operation:
  - Pending output is discarded; out_valid=0.
  - All keys return to KEY_DEFAULT and last_grant to NCH-1.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, in_ready=0, state EMPTY.
- Latency: a beat accepted at edge k has out_valid=1 from edge k, i.e. visible in cycle k+1.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Fairness: with all channels continuously valid, grants rotate 0,1,…,NCH-1. No channel waits more than NCH-1 accepts.
- Seed takes effect for the next beat of that channel, at the earliest the following cycle.

## Configuration
- Macro: STREAM_CIPHER_CTRL_STATS_EN.
- Defined:
  - Adds output port beat_cnt (NCH*16 bits): per-channel count of accepted keystream-mode beats.
  - Counters saturate at 16'hFFFF.
  - A channel's counter clears when that channel is seeded; all clear on reset.
- Undefined: the port and counters are absent. All other behaviour is identical.

## Structure
- Package stream_cipher_pkg holds:
  - KEY_DEFAULT and TAPS constants.
  - The FSM state enum {EMPTY, FULL}.
  - Function lfsr_next(key, taps).
- One sub-module, stream_cipher_rr_arb: inputs are the request vector and last_grant; outputs are a one-hot grant and its encoded index.

## Test plan
- Reset, then ch0 sends 8'h00 (mode 1) twice with out_ready=1 → out_data 8'hCD then 8'h9A, out_ch=0. key[0] ends at 8'h35.
- Encrypt 8'h3C on ch1, then reset, then decrypt the resulting 8'hF1 on ch1 → out_data 8'h3C, confirming the round trip.
- Both channels continuously valid, mode 1, data 8'h00, out_ready=1 for 4 cycles → out_ch sequence 0,1,0,1 and data sequence CD,CD,9A,9A.
- Hold out_ready=0 for 3 cycles while FULL → out_data and out_ch stable, in_ready=0, keys unchanged. Release → one beat per cycle resumes with nothing lost or duplicated.
- seed_we to ch0 with 8'h01 in the same cycle ch0 is valid → ch0 not granted that cycle. Its next beat of 8'h00 outputs 8'h01.
- Bypass beat 8'h55 on ch0 (mode 0) → out 8'h55. The following mode-1 beat still uses key 8'hCD. With STREAM_CIPHER_CTRL_STATS_EN defined, ch0's counter increments only for the mode-1 beat.
